keypad_matrix_scanner: RTL and testbench

//  Input-side counterpart of the seven-segment scan controller on the FPGA top.

---
 rtl/keypad_matrix_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-strobed key matrix scanner with per-key debounce
// and a press/release event FIFO drained through a valid/ready port.
// Optional feature macro: KEYPAD_RELEASE_EVT_EN (queue release events too).
module keypad_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  output logic [ROWS-1:0]      row_n_o,
  input  logic [COLS-1:0]      col_n_i,
  output logic                 key_valid_o,
  output logic [7:0]           key_code_o,
  input  logic                 key_ready_i,
  output logic                 overflow_o,
  input  logic                 clr_ovf_i,
  output logic [ROWS*COLS-1:0] key_state_o
);
  localparam int NK = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {DWELL, EVAL, NEXT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [COLS-1:0] sync1_q, sync2_q;
  logic [COLS-1:0] snap_q;            // pressed bits (active-high) of the current row
  logic [NK-1:0]   key_state_q;
  logic [DW-1:0]   cnt_q [NK];

  logic            eval, sample, flip, push, pop, full, wr_en;
  logic [KW-1:0]   k_idx;
  logic [7:0]      ev_code;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     count_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs; idle = released.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= col_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= DWELL;
    else          state_q <= state_d;
  end

  // Scan FSM next state: dwell on a row, evaluate each column, step to next row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DWELL:   if (presc_q == PW'(SCAN_DIV - 1)) state_d = EVAL;
      EVAL:    if (col_q == CW'(COLS - 1))       state_d = NEXT;
      NEXT:    state_d = DWELL;
      default: state_d = DWELL;
    endcase
  end

  // Scan datapath: prescaler, column snapshot, column and row indices.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        DWELL: begin
          if (presc_q == PW'(SCAN_DIV - 1)) begin
            snap_q <= ~sync2_q;
            col_q  <= '0;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        EVAL: if (col_q != CW'(COLS - 1)) col_q <= col_q + CW'(1);
        NEXT: begin
          row_q   <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
          presc_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign row_n_o = ~(ROWS'(1) << row_q);
  assign eval    = (state_q == EVAL);
  assign k_idx   = KW'(int'(row_q) * COLS + int'(col_q));
  assign sample  = snap_q[col_q];
  assign flip    = eval && (sample != key_state_q[k_idx]) &&
                   (cnt_q[k_idx] == DW'(DEBOUNCE_SCANS - 1));
`ifdef KEYPAD_RELEASE_EVT_EN
  assign push    = flip;
`else
  assign push    = flip && sample;    // releases only update the bitmap
`endif
  assign ev_code = {~sample, 3'(row_q), 4'(col_q)};

  // Per-key debounce: a key flips only after DEBOUNCE_SCANS consecutive differing samples.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      key_state_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else if (eval) begin
      for (int i = 0; i < NK; i++) begin
        if (k_idx == KW'(i)) begin
          if (sample == key_state_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == DW'(DEBOUNCE_SCANS - 1)) begin
            key_state_q[i] <= ~key_state_q[i];
            cnt_q[i]       <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + DW'(1);
          end
        end
      end
    end
  end

  assign key_state_o = key_state_q;
  assign key_valid_o = (count_q != '0);
  assign key_code_o  = mem_q[rd_q];
  assign full        = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop         = key_valid_o && key_ready_i;
  assign wr_en       = push && (!full || pop);

  // Event FIFO; a pop in the same cycle frees room for a push into a full FIFO.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= ev_code;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)                   overflow_o <= 1'b0;
    else if (push && full && !pop)  overflow_o <= 1'b1;
    else if (clr_ovf_i)             overflow_o <= 1'b0;
  end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed test of the keypad scanner with a
// behavioural key matrix (pressed key shorts its column to the driven row).
module tb_keypad_matrix_scanner;
  logic        clk_i = 1'b0;
  logic        reset_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ready;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] key_state;
  logic [15:0] keys;            // keys[r*4+c] = 1 -> key (r,c) held
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n), .row_n_o(row_n), .col_n_i(col_n),
    .key_valid_o(key_valid), .key_code_o(key_code), .key_ready_i(key_ready),
    .overflow_o(overflow), .clr_ovf_i(clr_ovf), .key_state_o(key_state)
  );

  always #5 clk_i = ~clk_i;

  // Key matrix model.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] rcode(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // Wait (bounded) until row r is strobed.
  task automatic wait_row(input int r);
    int t;
    t = 0;
    while (row_n !== rcode(r) && t < 200) begin @(negedge clk_i); t++; end
    chk("wait_row", row_n, rcode(r));
  endtask

  // Wait for a complete scan of row r; returns just after the switch to the next row.
  task automatic scan_row(input int r);
    int t;
    wait_row(r);
    t = 0;
    while (row_n === rcode(r) && t < 200) begin @(negedge clk_i); t++; end
    chk("scan_leave", row_n, rcode((r + 1) % 4));
  endtask

  task automatic wait_change(output int n);
    logic [3:0] prev;
    prev = row_n;
    n = 0;
    while (row_n === prev && n < 100) begin @(negedge clk_i); n++; end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, key_valid, 1);
    chk({tag, "_code"}, key_code, exp);
    key_ready = 1'b1;
    @(negedge clk_i);
    key_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; keys = '0; key_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk_i);
    // 1. reset state and idle row rotation
    chk("rst_row", row_n, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_state", key_state, 0);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_change(n);
      chk("row_period", n, 13);
      chk("row_seq", row_n, rcode(i % 4));
    end
    chk("idle_valid", key_valid, 0);

    // 3. bouncing key (2,1): alternating scans never reach the debounce count
    wait_row(0);
    keys[9] = 1'b1; scan_row(2);
    keys[9] = 1'b0; scan_row(2);
    keys[9] = 1'b1; scan_row(2);
    keys[9] = 1'b0; scan_row(2);
    chk("bounce_valid", key_valid, 0);
    chk("bounce_state", key_state[9], 0);

    // 2. held key (2,1): event after second row-2 scan, held while not ready
    keys[9] = 1'b1;
    scan_row(2);
    chk("press1_valid", key_valid, 0);
    chk("press1_state", key_state[9], 0);
    scan_row(2);
    chk("press2_valid", key_valid, 1);
    chk("press2_code", key_code, 8'h21);
    chk("press2_state", key_state[9], 1);
    repeat (30) @(negedge clk_i);
    pop_chk("press_hold", 8'h21);
    chk("press_empty", key_valid, 0);

    // 4. five presses into a 4-deep FIFO: last one dropped
    wait_row(3);
    keys[0] = 1'b1; keys[3] = 1'b1; keys[6] = 1'b1; keys[8] = 1'b1; keys[11] = 1'b1;
    scan_row(2);
    scan_row(2);
    chk("ovf_set", overflow, 1);
    chk("ovf_state", key_state, 16'h0B49);
    key_ready = 1'b0;
    pop_chk("q0", 8'h00);
    pop_chk("q1", 8'h03);
    pop_chk("q2", 8'h12);
    pop_chk("q3", 8'h20);
    chk("drain_empty", key_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk_i);
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // 5. release key (2,1)
    wait_row(3);
    keys[9] = 1'b0;
    scan_row(2);
    chk("rel1_state", key_state[9], 1);
    chk("rel1_valid", key_valid, 0);
    scan_row(2);
    chk("rel_state", key_state, 16'h0949);
`ifdef KEYPAD_RELEASE_EVT_EN
    pop_chk("rel_evt", 8'hA1);
`else
    chk("rel_noevt", key_valid, 0);
`endif
    chk("rel_ovf", overflow, 0);

    // 6. reset during EVAL with two events queued
    wait_row(3);
    keys[4] = 1'b1; keys[5] = 1'b1;
    scan_row(1);
    scan_row(1);
    chk("pre_rst_valid", key_valid, 1);
    chk("pre_rst_code", key_code, 8'h10);
    repeat (8) @(negedge clk_i);     // now in EVAL of row 2
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_row", row_n, 4'b1110);
    chk("mid_rst_state", key_state, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
